// File: rtl/regfile_writeback.sv
// Merges the ALU and long-latency result streams onto the single register file write port.
// Long-latency results are buffered in an in-order FIFO; a scoreboard tracks their pending writes.
module regfile_writeback #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  output logic [31:0]                   busy,
  output logic                          rf_regwrite,
  output logic [4:0]                    rf_writereg,
  output logic [XLEN-1:0]               rf_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [4:0]      rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q;
  logic            push, pop, fifo_empty;

  logic            rf_we_d, from_fifo_d, from_fifo_q;
  logic [4:0]      rf_rd_d;
  logic [XLEN-1:0] rf_data_d;

  logic [31:0]     busy_q, busy_d, set_vec, clr_vec;

  // ready_q holds mem_ready low through reset and releases it on the first edge after.
  assign mem_ready  = ready_q && (count_q < DepthCnt);
  assign fifo_empty = (count_q == '0);
  assign push       = mem_valid && mem_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign fifo_count = count_q;
  assign busy       = busy_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= mem_rd;
      data_mem[wr_ptr_q] <= mem_data;
    end
  end

  // ALU has priority; x0 slots are consumed but never raise the write enable.
  always_comb begin
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_writereg;
    rf_data_d   = rf_write_data;
    from_fifo_d = 1'b0;
    if (alu_valid) begin
      rf_we_d   = (alu_rd != 5'd0);
      rf_rd_d   = alu_rd;
      rf_data_d = alu_data;
    end else if (pop) begin
      rf_we_d     = (rd_mem[rd_ptr_q] != 5'd0);
      rf_rd_d     = rd_mem[rd_ptr_q];
      rf_data_d   = data_mem[rd_ptr_q];
      from_fifo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_regwrite   <= 1'b0;
      rf_writereg   <= 5'd0;
      rf_write_data <= '0;
      from_fifo_q   <= 1'b0;
    end else begin
      rf_regwrite   <= rf_we_d;
      rf_writereg   <= rf_rd_d;
      rf_write_data <= rf_data_d;
      from_fifo_q   <= from_fifo_d;
    end
  end

  // Clear on the commit of a FIFO-sourced write; a same-cycle issue to that register wins.
  always_comb begin
    set_vec = issue_valid ? (32'd1 << issue_rd) : 32'd0;
    clr_vec = (rf_regwrite && from_fifo_q) ? (32'd1 << rf_writereg) : 32'd0;
    busy_d  = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: each step drives one cycle of inputs, then checks
// the registered outputs one edge later against hand-computed values.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        rf_regwrite;
  logic [4:0]  rf_writereg;
  logic [31:0] rf_write_data;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy         (busy),
    .rf_regwrite  (rf_regwrite),
    .rf_writereg  (rf_writereg),
    .rf_write_data(rf_write_data),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0;

    // Held in reset
    tick();
    tick();
    chk("rst_regwrite", 32'(rf_regwrite), 32'd0);
    chk("rst_ready",    32'(mem_ready),   32'd0);
    chk("rst_busy",     busy,             32'd0);
    chk("rst_count",    32'(fifo_count),  32'd0);
    rst = 1'b1;
    tick();
    chk("rel_ready",    32'(mem_ready),   32'd1);
    chk("rel_regwrite", 32'(rf_regwrite), 32'd0);
    chk("rel_busy",     busy,             32'd0);
    chk("rel_count",    32'(fifo_count),  32'd0);

    // Single ALU write, visible exactly one cycle
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("alu_we",   32'(rf_regwrite), 32'd1);
    chk("alu_rd",   32'(rf_writereg), 32'd5);
    chk("alu_data", rf_write_data,    32'hDEADBEEF);
    tick();
    chk("alu_we_off",    32'(rf_regwrite), 32'd0);
    chk("alu_rd_hold",   32'(rf_writereg), 32'd5);
    chk("alu_data_hold", rf_write_data,    32'hDEADBEEF);

    // Scoreboard round trip on x7
    issue_valid = 1'b1; issue_rd = 5'd7;           // cycle 0
    tick();
    issue_valid = 1'b0;
    chk("sb_set", busy, 32'h0000_0080);            // cycle 1
    tick();
    tick();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;  // cycle 3
    tick();
    mem_valid = 1'b0;
    chk("sb_c4_count", 32'(fifo_count),  32'd1);
    chk("sb_c4_we",    32'(rf_regwrite), 32'd0);
    tick();                                        // cycle 5
    chk("sb_c5_we",   32'(rf_regwrite), 32'd1);
    chk("sb_c5_rd",   32'(rf_writereg), 32'd7);
    chk("sb_c5_data", rf_write_data,    32'h1234);
    chk("sb_c5_busy", busy,             32'h0000_0080);
    chk("sb_c5_cnt",  32'(fifo_count),  32'd0);
    tick();                                        // cycle 6
    chk("sb_c6_busy", busy,             32'd0);
    chk("sb_c6_we",   32'(rf_regwrite), 32'd0);

    // ALU starvation: 5 mem offers under 6 ALU cycles, only 4 fit
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'(k);
      mem_valid = (k < 5); mem_rd = 5'(10 + k); mem_data = 32'hA0 + 32'(k);
      chk($sformatf("stv_ready%0d", k), 32'(mem_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("stv_rd%0d", k), 32'(rf_writereg), 32'(k + 1));
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("stv_full_cnt",   32'(fifo_count), 32'd4);
    chk("stv_full_ready", 32'(mem_ready),  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain_we%0d", i),   32'(rf_regwrite), 32'd1);
      chk($sformatf("drain_rd%0d", i),   32'(rf_writereg), 32'(10 + i));
      chk($sformatf("drain_data%0d", i), rf_write_data,    32'hA0 + 32'(i));
    end
    chk("drain_cnt", 32'(fifo_count), 32'd0);
    tick();
    chk("drain_idle", 32'(rf_regwrite), 32'd0);

    // x0 writes from both sources, plus an issue to x0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h66;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_rd = 5'd0;
    chk("x0_alu_we", 32'(rf_regwrite), 32'd0);
    chk("x0_cnt1",   32'(fifo_count),  32'd1);
    tick();
    issue_valid = 1'b0;
    chk("x0_pop_we", 32'(rf_regwrite), 32'd0);
    chk("x0_cnt0",   32'(fifo_count),  32'd0);
    chk("x0_busy",   busy,             32'h0000_0008);
    tick();
    chk("x0_we_idle", 32'(rf_regwrite), 32'd0);
    chk("x0_busy2",   busy,             32'h0000_0008);

    // Reset mid-operation with 3 buffered entries
    issue_valid = 1'b1; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h77;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h301;
    tick();
    issue_rd = 5'd12; mem_rd = 5'd9; mem_data = 32'h901;
    tick();
    issue_valid = 1'b0; mem_rd = 5'd12; mem_data = 32'hC01;
    tick();
    mem_valid = 1'b0;
    chk("mid_cnt3",  32'(fifo_count), 32'd3);
    chk("mid_busy",  busy,            32'h0000_1208);
    chk("mid_we",    32'(rf_regwrite), 32'd1);
    alu_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_we",    32'(rf_regwrite), 32'd0);
    chk("arst_rd",    32'(rf_writereg), 32'd0);
    chk("arst_data",  rf_write_data,    32'd0);
    chk("arst_cnt",   32'(fifo_count),  32'd0);
    chk("arst_busy",  busy,             32'd0);
    chk("arst_ready", 32'(mem_ready),   32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_we",    32'(rf_regwrite), 32'd0);
    chk("post_cnt",   32'(fifo_count),  32'd0);
    chk("post_ready", 32'(mem_ready),   32'd1);
    chk("post_busy",  busy,             32'd0);
    tick();
    chk("post_we2",   32'(rf_regwrite), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Writer-side front end for the 32x32 register file. It merges two result streams into the file's single write port. The single-cycle ALU stream is always accepted. The long-latency memory/multiply stream is buffered in a small FIFO. The block also keeps a pending-write scoreboard so decode can stall on registers whose long-latency result has not yet been committed. It sits between execute/memory and the register file write port (regwrite, writereg, write_data).

Parameters:
XLEN, 32, data width of results and of the write port
FIFO_DEPTH, 4, entries in the long-latency result FIFO (power of 2, at least 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU result present this cycle; never back-pressured
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
mem_valid  input  1  long-latency result offered
mem_ready  output  1  FIFO can accept; transfer when mem_valid and mem_ready
mem_rd  input  5  long-latency destination register
mem_data  input  XLEN  long-latency result
issue_valid  input  1  a long-latency op targeting issue_rd was issued this cycle
issue_rd  input  5  destination of the issued long-latency op
busy  output  32  scoreboard; bit k high means a write to xk is pending
rf_regwrite  output  1  register file write enable (registered)
rf_writereg  output  5  register file write address (registered)
rf_write_data  output  XLEN  register file write data (registered)
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous):
  - rf_regwrite=0, rf_writereg=0, rf_write_data=0.
  - busy=0, FIFO emptied, fifo_count=0.
  - mem_ready=0 while rst is low; mem_ready=1 from the first cycle after release.
  - Reset mid-operation discards all buffered results and pending bits.
- mem_ready = (fifo_count < FIFO_DEPTH), from registered count only. A pop in the same cycle does not raise mem_ready.
- Push: when mem_valid && mem_ready, {mem_rd, mem_data} is written at the tail. It is visible at the head no earlier than the next cycle (no bypass).
- Write-port arbitration each cycle, registered at the rising edge:
  - If alu_valid: the ALU result wins. rf_* is driven with alu_rd/alu_data in the next cycle. The FIFO is not popped.
  - Else if the FIFO is not empty: pop the head and drive rf_* with it in the next cycle.
  - Else: rf_regwrite=0 next cycle. rf_writereg and rf_write_data hold their previous values.
- Writes to x0: consumed or popped normally, but rf_regwrite=0 for that slot. x0 is never written.
- Latency:
  - ALU result at cycle N appears on rf_* in cycle N+1.
  - mem result pushed at cycle N appears on rf_* in cycle N+2 at the earliest, and later under ALU contention.
- FIFO ordering: strict in-order. The count updates by +1, -1 or 0 on simultaneous push and pop. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] at the next edge.
  - Clear: busy[k] clears at the edge ending the cycle in which rf_regwrite=1 for a FIFO-sourced write to k, i.e. when the register file commits it. busy[k] is low the following cycle.
  - ALU-sourced writes never clear busy.
  - Simultaneous set and clear of the same register: set wins.
  - busy[0] is constantly 0.
- Sustained alu_valid starves the FIFO. The FIFO fills and mem_ready drops; no data is lost. Fairness is issue logic's responsibility.
- No handshake signal may change state combinationally from busy.

Test Plan:
- Reset release, idle: rf_regwrite=0, busy=0, fifo_count=0, mem_ready=1 in the first cycle after rst goes high.
- alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> rf_regwrite=1, rf_writereg=5, rf_write_data=0xDEADBEEF in cycle N+1 only.
- issue_rd=7 at cycle 0; mem result rd=7, data=0x1234 pushed at cycle 3 with no ALU traffic -> busy[7]=1 from cycle 1, rf write of x7=0x1234 in cycle 5, busy[7]=0 from cycle 6.
- ALU valid every cycle for 6 cycles while 5 mem results are offered -> 4 accepted, mem_ready=0 with fifo_count=4, then the FIFO drains in push order once ALU traffic stops.
- mem result with rd=0 and alu_rd=0 -> both consumed, rf_regwrite stays 0, busy unchanged.
- FIFO holding 3 entries with busy bits set, rst pulsed low mid-cycle -> outputs zero immediately, fifo_count=0, busy=0, no rf write after release.
